// File: rtl/blake2_io_stream.sv
// blake2_io_stream
// Byte-serial I/O front end for a BLAKE2 core (BLAKE2s with BB=64, BLAKE2b with BB=128).
//
// Input beats {cmd, byte} are written into one in-order FIFO. The entry at the FIFO head
// is then either consumed as configuration or forwarded to the core as a data byte with
// block framing.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   en_i                    slice enable (registered to en_q)
//   valid_i/cmd_i/data_i    input beat (cmd: 0 CONF, 1 START, 2 DATA, 3 LAST)
//   loopback_mode_i         hash_o source select (0 core, 1 data_o, 2/3 status)
//   in_ready_o              FIFO not full
//   overflow_o              sticky: a beat arrived while the FIFO was full
//   core_ready_i            core can take a data byte
//   ready_v_i/ready_v_o     core idle, qualified by an empty front end
//   hash_v_i/hash_i         core hash byte
//   hash_v_o/hash_o         hash byte out, through the loopback mux
//   kk_o/nn_o/ll_o          key length, digest length, message length
//   cfg_done_o, cfg_err_o   config-complete pulse, sticky range error
//   data_v_o/data_o         data byte to the core
//   data_idx_o              byte index within the block
//   block_first_o           current block was opened by START
//   block_last_o            this byte is the LAST byte
//   block_end_o             final byte of the block
module blake2_io_stream #(
  parameter int BB         = 64,
  parameter int LL_BYTES   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  logic                      valid_i,
  input  logic [1:0]                cmd_i,
  input  logic [7:0]                data_i,
  input  logic [1:0]                loopback_mode_i,
  output logic                      in_ready_o,
  output logic                      overflow_o,
  input  logic                      core_ready_i,
  input  logic                      ready_v_i,
  input  logic                      hash_v_i,
  input  logic [7:0]                hash_i,
  output logic                      ready_v_o,
  output logic                      hash_v_o,
  output logic [7:0]                hash_o,
  output logic [$clog2(BB/2):0]     kk_o,
  output logic [$clog2(BB/2):0]     nn_o,
  output logic [8*LL_BYTES-1:0]     ll_o,
  output logic                      cfg_done_o,
  output logic                      cfg_err_o,
  output logic                      data_v_o,
  output logic [7:0]                data_o,
  output logic [$clog2(BB)-1:0]     data_idx_o,
  output logic                      block_first_o,
  output logic                      block_last_o,
  output logic                      block_end_o
);

  localparam int IDX_W = $clog2(BB);
  localparam int KN_W  = $clog2(BB/2) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(LL_BYTES + 2);
  localparam int LLW   = 8 * LL_BYTES;

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  // FIFO storage and control
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          en_q, en_d;
  logic [1:0]    loop_q, loop_d;

  // Config state; the range flags are captured at load time from the full byte
  logic [CW-1:0]   cfg_cnt_q, cfg_cnt_d;
  logic [KN_W-1:0] kk_q, kk_d;
  logic [KN_W-1:0] nn_q, nn_d;
  logic            kk_bad_q, kk_bad_d;
  logic            nn_bad_q, nn_bad_d;
  logic [LLW-1:0]  ll_q, ll_d;
  logic            cfg_done_q, cfg_done_d;
  logic            cfg_err_q, cfg_err_d;

  // Data output state
  logic [IDX_W-1:0] data_cnt_q, data_cnt_d;
  logic             data_v_q, data_v_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             end_q, end_d;

  logic       valid, full, empty, pop, push, conf_pop, data_pop, blk_end;
  logic [9:0] head;
  logic [1:0] head_cmd;
  logic [7:0] head_byte;
  logic [3:0] occ4;

  always_comb begin
    valid     = en_q & valid_i;
    full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    empty     = (cnt_q == '0);
    head      = mem_q[rd_q];
    head_cmd  = head[9:8];
    head_byte = head[7:0];
    // CONF heads never wait for the core; data heads need core_ready_i
    pop       = ~empty & ((head_cmd == CMD_CONF) | core_ready_i);
    conf_pop  = pop & (head_cmd == CMD_CONF);
    data_pop  = pop & (head_cmd != CMD_CONF);
    // A full FIFO still takes a beat when the head leaves on the same edge
    push      = valid & (~full | pop);
    blk_end   = (data_cnt_q == IDX_W'(BB-1)) | (head_cmd == CMD_LAST);

    wr_d       = push ? wr_q + AW'(1) : wr_q;
    rd_d       = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d      = cnt_q;
    if (push & ~pop) cnt_d = cnt_q + (AW+1)'(1);
    if (pop & ~push) cnt_d = cnt_q - (AW+1)'(1);
    ovf_d      = ovf_q | (valid & full & ~pop);

    en_d       = en_i;
    loop_d     = en_q ? loopback_mode_i : loop_q;

    cfg_cnt_d  = cfg_cnt_q;
    kk_d       = kk_q;
    nn_d       = nn_q;
    kk_bad_d   = kk_bad_q;
    nn_bad_d   = nn_bad_q;
    ll_d       = ll_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = cfg_err_q;

    data_cnt_d = data_cnt_q;
    data_v_d   = 1'b0;
    data_d     = data_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_d     = 1'b0;
    end_d      = 1'b0;

    if (conf_pop) begin
      data_cnt_d = '0;
      if (cfg_cnt_q == CW'(0)) begin
        kk_d      = head_byte[KN_W-1:0];
        kk_bad_d  = (head_byte > 8'(BB/2));
        cfg_err_d = 1'b0;
      end else if (cfg_cnt_q == CW'(1)) begin
        nn_d     = head_byte[KN_W-1:0];
        nn_bad_d = (head_byte == 8'd0) | (head_byte > 8'(BB/2));
      end else begin
        // Little-endian length: each new byte enters at the top and slides down
        ll_d = {head_byte, ll_q[LLW-1:8]};
      end
      if (cfg_cnt_q == CW'(LL_BYTES+1)) begin
        cfg_cnt_d  = '0;
        cfg_done_d = 1'b1;
        cfg_err_d  = kk_bad_q | nn_bad_q;
      end else begin
        cfg_cnt_d = cfg_cnt_q + CW'(1);
      end
    end

    if (data_pop) begin
      cfg_cnt_d  = '0;
      data_v_d   = 1'b1;
      data_d     = head_byte;
      idx_d      = data_cnt_q;
      last_d     = (head_cmd == CMD_LAST);
      end_d      = blk_end;
      // Only idx 0 decides block_first; a mid-block START is plain data
      if (data_cnt_q == '0) first_d = (head_cmd == CMD_START);
      data_cnt_d = blk_end ? '0 : data_cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
      loop_q     <= '0;
      cfg_cnt_q  <= '0;
      kk_q       <= '0;
      nn_q       <= '0;
      kk_bad_q   <= 1'b0;
      nn_bad_q   <= 1'b0;
      ll_q       <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      data_cnt_q <= '0;
      data_v_q   <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
      loop_q     <= loop_d;
      cfg_cnt_q  <= cfg_cnt_d;
      kk_q       <= kk_d;
      nn_q       <= nn_d;
      kk_bad_q   <= kk_bad_d;
      nn_bad_q   <= nn_bad_d;
      ll_q       <= ll_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      data_cnt_q <= data_cnt_d;
      data_v_q   <= data_v_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      last_q     <= last_d;
      end_q      <= end_d;
    end
  end

  // Entry storage needs no reset: the empty count guards every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_i, data_i};
  end

  always_comb begin
    occ4 = 4'(cnt_q);
    case (loop_q)
      2'd0:    hash_o = hash_i;
      2'd1:    hash_o = data_q;
      default: hash_o = {occ4, cfg_err_q, ovf_q, first_q, last_q};
    endcase
  end

  assign in_ready_o    = ~full;
  assign overflow_o    = ovf_q;
  assign ready_v_o     = ready_v_i & ~data_v_q & empty;
  assign hash_v_o      = hash_v_i;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign ll_o          = ll_q;
  assign cfg_done_o    = cfg_done_q;
  assign cfg_err_o     = cfg_err_q;
  assign data_v_o      = data_v_q;
  assign data_o        = data_q;
  assign data_idx_o    = idx_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign block_end_o   = end_q;

endmodule

// File: tb/tb_blake2_io_stream.sv
// Testbench for blake2_io_stream: directed scenarios followed by randomized traffic.
// A queue-based reference model predicts every output after each clock edge.
module tb_blake2_io_stream;

  localparam int BB    = 64;
  localparam int LLB   = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 6;
  localparam int KN_W  = 6;

  logic             clk;
  logic             reset;
  logic             en_i;
  logic             valid_i;
  logic [1:0]       cmd_i;
  logic [7:0]       data_i;
  logic [1:0]       loopback_mode_i;
  logic             in_ready_o;
  logic             overflow_o;
  logic             core_ready_i;
  logic             ready_v_i;
  logic             hash_v_i;
  logic [7:0]       hash_i;
  logic             ready_v_o;
  logic             hash_v_o;
  logic [7:0]       hash_o;
  logic [KN_W-1:0]  kk_o;
  logic [KN_W-1:0]  nn_o;
  logic [8*LLB-1:0] ll_o;
  logic             cfg_done_o;
  logic             cfg_err_o;
  logic             data_v_o;
  logic [7:0]       data_o;
  logic [IDX_W-1:0] data_idx_o;
  logic             block_first_o;
  logic             block_last_o;
  logic             block_end_o;

  blake2_io_stream #(.BB(BB), .LL_BYTES(LLB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .valid_i(valid_i), .cmd_i(cmd_i),
    .data_i(data_i), .loopback_mode_i(loopback_mode_i), .in_ready_o(in_ready_o),
    .overflow_o(overflow_o), .core_ready_i(core_ready_i), .ready_v_i(ready_v_i),
    .hash_v_i(hash_v_i), .hash_i(hash_i), .ready_v_o(ready_v_o), .hash_v_o(hash_v_o),
    .hash_o(hash_o), .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .cfg_done_o(cfg_done_o),
    .cfg_err_o(cfg_err_o), .data_v_o(data_v_o), .data_o(data_o), .data_idx_o(data_idx_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o), .block_end_o(block_end_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] b;
  } beat_t;

  // Reference model state
  beat_t       mq[$];
  bit          m_en, m_ovf, m_done, m_err, m_dv, m_first, m_last, m_end;
  logic [1:0]  m_loop;
  int          m_cfgcnt, m_datacnt, m_kk, m_nn, m_data, m_idx;
  logic [63:0] m_ll;

  // Observations for the directed scenarios
  int n_done, n_end, n_last, n_first;
  int obs_idx[$];
  int obs_data[$];
  int obs_hash[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic model_edge();
    bit    v, full, pop;
    beat_t h;
    if (reset) begin
      mq.delete();
      m_en = 0; m_ovf = 0; m_done = 0; m_err = 0; m_dv = 0;
      m_first = 0; m_last = 0; m_end = 0; m_loop = 2'd0;
      m_cfgcnt = 0; m_datacnt = 0; m_kk = 0; m_nn = 0; m_data = 0; m_idx = 0;
      m_ll = '0;
      return;
    end
    v    = m_en && valid_i;
    full = (mq.size() == DEPTH);
    pop  = 0;
    h    = '0;
    if (mq.size() != 0) begin
      h   = mq[0];
      pop = (h.cmd == 2'd0) || core_ready_i;
    end
    m_done = 0; m_dv = 0; m_last = 0; m_end = 0;
    if (pop) begin
      h = mq.pop_front();
      if (h.cmd == 2'd0) begin
        m_datacnt = 0;
        if (m_cfgcnt == 0) begin
          m_kk  = int'(h.b);
          m_err = 0;
        end else if (m_cfgcnt == 1) begin
          m_nn = int'(h.b);
        end else begin
          m_ll = {h.b, m_ll[63:8]};
        end
        if (m_cfgcnt == LLB + 1) begin
          m_cfgcnt = 0;
          m_done   = 1;
          m_err    = (m_kk > BB/2) || (m_nn == 0) || (m_nn > BB/2);
        end else begin
          m_cfgcnt++;
        end
      end else begin
        m_cfgcnt = 0;
        m_dv     = 1;
        m_data   = int'(h.b);
        m_idx    = m_datacnt;
        if (m_datacnt == 0) m_first = (h.cmd == 2'd1);
        m_last    = (h.cmd == 2'd3);
        m_end     = (m_datacnt == BB-1) || (h.cmd == 2'd3);
        m_datacnt = m_end ? 0 : m_datacnt + 1;
      end
    end
    if (v) begin
      if (!full || pop) mq.push_back({cmd_i, data_i});
      else m_ovf = 1;
    end
    if (m_en) m_loop = loopback_mode_i;
    m_en = en_i;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_hash;
    logic [3:0] occ;
    occ = 4'(mq.size());
    case (m_loop)
      2'd0:    exp_hash = hash_i;
      2'd1:    exp_hash = 8'(m_data);
      default: exp_hash = {occ, m_err, m_ovf, m_first, m_last};
    endcase
    chk("in_ready",    64'(in_ready_o),    64'(mq.size() < DEPTH));
    chk("overflow",    64'(overflow_o),    64'(m_ovf));
    chk("kk",          64'(kk_o),          64'(m_kk % BB));
    chk("nn",          64'(nn_o),          64'(m_nn % BB));
    chk("ll",          64'(ll_o),          m_ll);
    chk("cfg_done",    64'(cfg_done_o),    64'(m_done));
    chk("cfg_err",     64'(cfg_err_o),     64'(m_err));
    chk("data_v",      64'(data_v_o),      64'(m_dv));
    chk("block_first", 64'(block_first_o), 64'(m_first));
    chk("block_last",  64'(block_last_o),  64'(m_last));
    chk("block_end",   64'(block_end_o),   64'(m_end));
    chk("hash_o",      64'(hash_o),        64'(exp_hash));
    chk("hash_v",      64'(hash_v_o),      64'(hash_v_i));
    chk("ready_v",     64'(ready_v_o),     64'(ready_v_i && !m_dv && mq.size() == 0));
    if (m_dv) begin
      chk("data_o",   64'(data_o),     64'(m_data));
      chk("data_idx", 64'(data_idx_o), 64'(m_idx));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
    if (cfg_done_o) n_done++;
    if (data_v_o) begin
      obs_idx.push_back(int'(data_idx_o));
      obs_data.push_back(int'(data_o));
      obs_hash.push_back(int'(hash_o));
      if (block_end_o) n_end++;
      if (block_last_o) n_last++;
      if (block_first_o) n_first++;
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] b);
    valid_i = 1'b1;
    cmd_i   = c;
    data_i  = b;
    step();
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    n_done = 0; n_end = 0; n_last = 0; n_first = 0;
    obs_idx.delete();
    obs_data.delete();
    obs_hash.delete();
  endtask

  initial begin
    reset = 1'b1; en_i = 1'b1; valid_i = 1'b0; cmd_i = 2'd0; data_i = 8'd0;
    loopback_mode_i = 2'd0; core_ready_i = 1'b1; ready_v_i = 1'b0;
    hash_v_i = 1'b0; hash_i = 8'd0;
    clear_obs();
    idle(2);
    chk("reset_in_ready", 64'(in_ready_o), 64'd1);
    chk("reset_data_v",   64'(data_v_o),   64'd0);
    reset = 1'b0;
    idle(2);

    // Config: kk=32, nn=32, ll=1
    clear_obs();
    send(2'd0, 8'h20);
    send(2'd0, 8'h20);
    send(2'd0, 8'h01);
    for (int i = 0; i < 7; i++) send(2'd0, 8'h00);
    idle(3);
    chk("cfg_done_count", 64'(n_done),    64'd1);
    chk("cfg_kk",         64'(kk_o),      64'd32);
    chk("cfg_nn",         64'(nn_o),      64'd32);
    chk("cfg_ll",         64'(ll_o),      64'd1);
    chk("cfg_err_clean",  64'(cfg_err_o), 64'd0);

    // Config range error: nn=0x21, then a new kk byte clears it
    send(2'd0, 8'h20);
    send(2'd0, 8'h21);
    for (int i = 0; i < 8; i++) send(2'd0, 8'h00);
    idle(3);
    chk("cfg_err_set", 64'(cfg_err_o), 64'd1);
    send(2'd0, 8'h10);
    idle(2);
    chk("cfg_err_clr", 64'(cfg_err_o), 64'd0);

    // Full block: START + 63 DATA
    clear_obs();
    send(2'd1, 8'h00);
    for (int i = 1; i < 64; i++) send(2'd2, 8'(i));
    idle(4);
    chk("full_count",   64'(obs_idx.size()), 64'd64);
    chk("full_idx63",   64'(obs_idx[63]),    64'd63);
    chk("full_ends",    64'(n_end),          64'd1);
    chk("full_first",   64'(n_first),        64'd64);

    // Partial block: START, DATA x4, LAST, then a new START
    clear_obs();
    send(2'd1, 8'h11);
    for (int i = 0; i < 4; i++) send(2'd2, 8'(8'h20 + i));
    send(2'd3, 8'h33);
    send(2'd1, 8'h44);
    idle(4);
    chk("part_count", 64'(obs_idx.size()), 64'd7);
    chk("part_idx0",  64'(obs_idx[0]),     64'd0);
    chk("part_idx5",  64'(obs_idx[5]),     64'd5);
    chk("part_next",  64'(obs_idx[6]),     64'd0);
    chk("part_ends",  64'(n_end),          64'd1);
    chk("part_lasts", 64'(n_last),         64'd1);

    // Backpressure: 6 beats into a 4-deep FIFO while the core stalls
    clear_obs();
    core_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(2'd2, 8'(8'hA0 + i));
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    chk("bp_overflow", 64'(overflow_o), 64'd1);
    core_ready_i = 1'b1;
    idle(8);
    chk("bp_count", 64'(obs_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", 64'(obs_data[i]), 64'(8'hA0 + i));

    // Loopback of data_o onto hash_o
    clear_obs();
    loopback_mode_i = 2'd1;
    idle(1);
    send(2'd2, 8'h5A);
    send(2'd2, 8'hC3);
    send(2'd2, 8'h3C);
    idle(4);
    chk("lb_count", 64'(obs_hash.size()), 64'd3);
    chk("lb_0", 64'(obs_hash[0]), 64'h5A);
    chk("lb_1", 64'(obs_hash[1]), 64'hC3);
    chk("lb_2", 64'(obs_hash[2]), 64'h3C);

    // Reset with three entries queued
    loopback_mode_i = 2'd2;
    core_ready_i    = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd2, 8'(8'h70 + i));
    idle(1);
    chk("pre_reset_occ", 64'(hash_o[7:4]), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_data_v",   64'(data_v_o),   64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    ready_v_i = 1'b1;
    idle(2);
    chk("post_reset_occ", 64'(hash_o[7:4]), 64'd0);
    chk("post_reset_rdy", 64'(ready_v_o),   64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 149) == 0);
      en_i         = ($urandom_range(0, 7) != 0);
      valid_i      = ($urandom_range(0, 2) != 0);
      cmd_i        = 2'($urandom_range(0, 3));
      data_i       = 8'($urandom);
      core_ready_i = ($urandom_range(0, 9) < 7);
      ready_v_i    = 1'($urandom);
      hash_v_i     = 1'($urandom);
      hash_i       = 8'($urandom);
      if ($urandom_range(0, 19) == 0) loopback_mode_i = 2'($urandom);
      step();
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
